mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares the single 6-bit-address / 8-bit-data memory of the accumulator CPU between the CPU (port A) and a second bus master (port B, program loader / DMA). It sits between the requesters and the memory pins. It registers each request, sequences a fixed-latency read or write cycle, returns read data with a one-cycle acknowledge, and alternates grants round-robin. Port A can lock the bus for read-modify-write sequences.

## Interface
Parameters:
- MEM_LAT, 1: cycles the memory strobe is held per access (legal 1–8).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_a / req_b  in  1  access request; hold high until ack_x.
- we_a / we_b  in  1  1 = write, 0 = read; sampled at grant.
- adr_a / adr_b  in  6  word address; sampled at grant.
- wdata_a / wdata_b  in  8  write data; sampled at grant.
- lock_a  in  1  port A bus lock, sampled on ack_a cycle.
- gnt_a / gnt_b  out  1  high during the owning access's strobe cycles.
- ack_a / ack_b  out  1  one-cycle completion pulse.
- rdata  out  8  read data; valid on the ack cycle, held until the next read completes.
- mem_adr  out  6  memory address.
- mem_rd / mem_wr  out  1  memory read / write strobes.
- mem_dout  out  8  write data to memory.
- mem_doe  out  1  data-pin output enable (= mem_wr); the tristate buffer lives at top level.
- mem_din  in  8  read data from memory.

## Operation
- FSM states: IDLE, ACC, ACK.
- IDLE: evaluate requests every cycle.
  - If only one requester is active, grant it.
  - If both are active, grant the one not served last (last_srv register; reset value B, so A wins first).
  - If a lock is held, only A is eligible and req_b waits.
  - On grant: capture we/adr/wdata of the winner into internal registers, set owner, and go to ACC with lat_cnt = MEM_LAT-1.
- ACC: drive mem_adr/mem_dout from the captured registers.
  - Assert mem_rd (read) or mem_wr and mem_doe (write), and the owner's gnt_x.
  - lat_cnt decrements each cycle. On the cycle lat_cnt = 0:
    - For a read, rdata <= mem_din.
    - For a write, rdata is unchanged.
  - Then go to ACK.
- ACK: pulse ack_x for the owner and update last_srv to the owner.
  - If the owner is A, lock <= lock_a.
  - Arbitration also runs in this cycle using the IDLE rules. A req_x still high here is a new request, so back-to-back accesses are possible. With no request, go to IDLE.
- Lock:
  - Only port A can lock. The lock is set or cleared only on an ack_a cycle.
  - While the lock is set and req_a is low, the bus idles; B stays blocked until A completes an access with lock_a = 0.
- Request fields are captured at grant. Changes to them during ACC/ACK do not affect the current access.
- A deasserting req before its ack is illegal. The access still completes and ack still pulses.

## Timing
- Reset values: gnt_a = gnt_b = ack_a = ack_b = 0, mem_rd = mem_wr = mem_doe = 0, mem_adr = 0, mem_dout = 0, rdata = 0, state = IDLE, lock = 0, last_srv = B.
- Latency, from the cycle req is sampled high in IDLE/ACK to the ack cycle: MEM_LAT + 1 cycles. Throughput for one requester is one access per MEM_LAT + 1 cycles.
- Strobes are high for exactly MEM_LAT consecutive cycles per access. They are never high in IDLE or ACK.
- mem_rd and mem_wr are never high together. gnt_a and gnt_b are never high together.
- ack is never asserted without a preceding ACC for that port.
- Reset mid-ACC: strobes, gnt and mem_doe drop in the cycle after the reset edge. No ack is issued for the aborted access, and the lock clears.
- Simultaneous req_a/req_b arriving in an ACK cycle: the round-robin rule applies with last_srv updated by that same ACK. The port just served loses if the other port is requesting.

## Test plan
- Single read, MEM_LAT = 1: req_a with adr_a = 0x15, mem_din = 0xA7 → mem_rd high for one cycle with mem_adr = 0x15; ack_a on cycle 2 with rdata = 0xA7.
- Write, MEM_LAT = 3: req_b, we_b = 1, adr_b = 0x3F, wdata_b = 0x5C → mem_wr and mem_doe high for 3 cycles with mem_dout = 0x5C; ack_b on cycle 4; rdata unchanged.
- Contention: req_a and req_b held high from reset release → grants alternate A, B, A, B with no idle cycle between accesses; gnt is never dual.
- Lock: A reads with lock_a = 1 while req_b is high → the next grant goes to A even though B is waiting; after A writes with lock_a = 0, B is granted next.
- Reset mid-access: reset asserted on the second ACC cycle (MEM_LAT = 3) → all outputs are at reset values the next cycle; no ack; the following req_b is granted first cycle after release only if req_a is low.
- Field stability: change adr_a/wdata_a in the cycle after grant → memory sees the values captured at grant.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of the 6-bit-address / 8-bit-data CPU memory.
// Port A is the CPU and may lock the bus across accesses; port B is the loader/DMA master.
module mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       we_a,
    input  logic       we_b,
    input  logic [5:0] adr_a,
    input  logic [5:0] adr_b,
    input  logic [7:0] wdata_a,
    input  logic [7:0] wdata_b,
    input  logic       lock_a,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       ack_a,
    output logic       ack_b,
    output logic [7:0] rdata,
    output logic [5:0] mem_adr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [7:0] mem_dout,
    output logic       mem_doe,
    input  logic [7:0] mem_din
);

    typedef enum logic [1:0] {IDLE, ACC, ACK} state_t;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    state_t     state_q;
    logic [2:0] lat_q;
    logic       owner_q;     // 0 = A, 1 = B
    logic       last_srv_q;  // 0 = A, 1 = B
    logic       lock_q;
    logic       we_q;
    logic       gnt_a_q, gnt_b_q, ack_a_q, ack_b_q;
    logic       mem_rd_q, mem_wr_q;
    logic [5:0] mem_adr_q;
    logic [7:0] mem_dout_q, rdata_q;

    // An ACK cycle arbitrates with the lock and last-served values that this same ACK commits.
    logic       lock_eff, last_eff, elig_b, pick_a, pick_b;
    logic       we_d;
    logic [5:0] adr_d;
    logic [7:0] wdata_d;

    always_comb begin
        lock_eff = (state_q == ACK && !owner_q) ? lock_a : lock_q;
        last_eff = (state_q == ACK) ? owner_q : last_srv_q;
        elig_b   = req_b && !lock_eff;
        pick_a   = req_a && (!elig_b || last_eff);
        pick_b   = elig_b && (!req_a || !last_eff);
        we_d     = pick_a ? we_a    : we_b;
        adr_d    = pick_a ? adr_a   : adr_b;
        wdata_d  = pick_a ? wdata_a : wdata_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lat_q      <= '0;
            owner_q    <= 1'b0;
            last_srv_q <= 1'b1;
            lock_q     <= 1'b0;
            we_q       <= 1'b0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_adr_q  <= '0;
            mem_dout_q <= '0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE, ACK: begin
                    ack_a_q <= 1'b0;
                    ack_b_q <= 1'b0;
                    if (state_q == ACK) begin
                        last_srv_q <= owner_q;
                        if (!owner_q)
                            lock_q <= lock_a;
                    end
                    if (pick_a || pick_b) begin
                        state_q    <= ACC;
                        lat_q      <= LAT_INIT;
                        owner_q    <= pick_b;
                        we_q       <= we_d;
                        mem_adr_q  <= adr_d;
                        mem_dout_q <= wdata_d;
                        mem_rd_q   <= !we_d;
                        mem_wr_q   <= we_d;
                        gnt_a_q    <= pick_a;
                        gnt_b_q    <= pick_b;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACC: begin
                    if (lat_q == 3'd0) begin
                        state_q  <= ACK;
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        gnt_a_q  <= 1'b0;
                        gnt_b_q  <= 1'b0;
                        ack_a_q  <= !owner_q;
                        ack_b_q  <= owner_q;
                        if (!we_q)
                            rdata_q <= mem_din;
                    end else begin
                        lat_q <= lat_q - 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_a    = gnt_a_q;
    assign gnt_b    = gnt_b_q;
    assign ack_a    = ack_a_q;
    assign ack_b    = ack_b_q;
    assign rdata    = rdata_q;
    assign mem_adr  = mem_adr_q;
    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;
    assign mem_doe  = mem_wr_q;
    assign mem_dout = mem_dout_q;

endmodule
